ff_sequencer: RTL and testbench

FF_SEQUENCER -- requirements
Module: ff_sequencer

---
 rtl/ff_sequencer_pkg.sv | 38 +++
 rtl/ff_valid_pipe.sv | 35 +++
 rtl/ff_sequencer.sv | 115 +++++++++++
 tb/tb_ff_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ff_sequencer_pkg.sv
// Shared types and derived-constant helpers for the feed-forward layer sequencer.
// All constants derive from the layer shape: fo, fi, p, n, z and LAT.
package ff_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Never returns 0, so a degenerate 1-entry range still gets a 1-bit port.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_c(input int p, input int fo, input int z);
    return (p * fo) / z;
  endfunction

  function automatic int calc_d(input int lat);
    return 1 + lat;
  endfunction

  function automatic int calc_pz(input int p, input int z);
    return p / z;
  endfunction

  localparam int C_DEFAULT  = calc_c(8, 2, 4);
  localparam int D_DEFAULT  = calc_d(1);
  localparam int PZ_DEFAULT = calc_pz(8, 4);

endpackage

// File: rtl/ff_valid_pipe.sv
// D-deep delay line carrying the issue strobe and its weight address to the output side.
// Bubbles from paused issue travel through unchanged, so output gaps mirror input gaps.
module ff_valid_pipe #(
  parameter int D  = 2,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic [D-1:0]  valid_reg;
  logic [AW-1:0] addr_reg [D];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
      for (int i = 0; i < D; i++) addr_reg[i] <= '0;
    end else begin
      valid_reg[0] <= in_valid;
      addr_reg[0]  <= in_valid ? in_addr : '0;
      for (int i = 1; i < D; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        addr_reg[i]  <= addr_reg[i-1];
      end
    end
  end

  assign out_valid = valid_reg[D-1];
  assign out_addr  = addr_reg[D-1];

endmodule

// File: rtl/ff_sequencer.sv
// Issue sequencer for one feed-forward layer: walks C memory read cycles per sample,
// then waits out the processor latency before signalling completion.
module ff_sequencer
  import ff_sequencer_pkg::*;
#(
  parameter int fo  = 2,
  parameter int fi  = 4,
  parameter int p   = 8,
  parameter int n   = 4,
  parameter int z   = 4,
  parameter int LAT = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        hold,
  output logic                                        rd_en,
  output logic [clog2_min1(calc_pz(p, z))-1:0]        act_addr,
  output logic [clog2_min1(calc_c(p, fo, z))-1:0]     w_addr,
  output logic                                        out_valid,
  output logic [clog2_min1(calc_c(p, fo, z))-1:0]     out_addr,
  output logic                                        busy,
  output logic                                        done,
  output logic [15:0]                                 sample_cnt
);

  localparam int C  = calc_c(p, fo, z);
  localparam int D  = calc_d(LAT);
  localparam int PZ = calc_pz(p, z);
  localparam int AW = clog2_min1(C);
  localparam int PW = clog2_min1(PZ);
  localparam int DW = clog2_min1(D);

  localparam logic [AW-1:0] C_LAST  = AW'(C - 1);
  localparam logic [PW-1:0] PZ_LAST = PW'(PZ - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(D - 1);

  // Reject layer shapes whose lane grouping does not tile the right layer exactly.
  if (((p * fo) % z) != 0 || (z % fi) != 0 || (C * (z / fi)) != n) begin : g_bad_shape
    $error("ff_sequencer: inconsistent layer shape parameters");
  end

  state_t          state_reg;
  logic [AW-1:0]   cyc_reg;
  logic [PW-1:0]   act_reg;
  logic [DW-1:0]   drain_reg;
  logic [15:0]     sample_cnt_reg;
  logic            issue;

  assign issue = (state_reg == ST_RUN) && !hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      cyc_reg        <= '0;
      act_reg        <= '0;
      drain_reg      <= '0;
      sample_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_RUN;
            cyc_reg   <= '0;
            act_reg   <= '0;
          end
        end
        ST_RUN: begin
          if (!hold) begin
            if (cyc_reg == C_LAST) begin
              state_reg <= ST_DRAIN;
              cyc_reg   <= '0;
              act_reg   <= '0;
              drain_reg <= '0;
            end else begin
              cyc_reg <= cyc_reg + 1'b1;
              // activation bank index wraps every p/z issues
              act_reg <= (act_reg == PZ_LAST) ? '0 : act_reg + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_reg == D_LAST) begin
            state_reg      <= ST_DONE;
            sample_cnt_reg <= sample_cnt_reg + 16'd1;
          end else begin
            drain_reg <= drain_reg + 1'b1;
          end
        end
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rd_en      = issue;
  assign w_addr     = (state_reg == ST_RUN) ? cyc_reg : '0;
  assign act_addr   = (state_reg == ST_RUN) ? act_reg : '0;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign sample_cnt = sample_cnt_reg;

  ff_valid_pipe #(
    .D  (D),
    .AW (AW)
  ) u_valid_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_en),
    .in_addr   (w_addr),
    .out_valid (out_valid),
    .out_addr  (out_addr)
  );

endmodule

// File: tb/tb_ff_sequencer.sv
// Directed checks of the sequencer: default build plus a LAT=3 build sharing clock and reset.
module tb_ff_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        start3 = 1'b0;

  logic        rd_en, out_valid, busy, done;
  logic [0:0]  act_addr;
  logic [1:0]  w_addr, out_addr;
  logic [15:0] sample_cnt;

  logic        rd_en_3, out_valid_3, busy_3, done_3;
  logic [0:0]  act_addr_3;
  logic [1:0]  w_addr_3, out_addr_3;
  logic [15:0] sample_cnt_3;

  int vectors = 0;
  int miscompares = 0;
  int ov_seen, done_seen;

  always #5 clk = ~clk;

  ff_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .rd_en(rd_en), .act_addr(act_addr), .w_addr(w_addr),
    .out_valid(out_valid), .out_addr(out_addr),
    .busy(busy), .done(done), .sample_cnt(sample_cnt)
  );

  ff_sequencer #(.LAT(3)) dut_lat3 (
    .clk(clk), .reset(reset), .start(start3), .hold(1'b0),
    .rd_en(rd_en_3), .act_addr(act_addr_3), .w_addr(w_addr_3),
    .out_valid(out_valid_3), .out_addr(out_addr_3),
    .busy(busy_3), .done(done_3), .sample_cnt(sample_cnt_3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input string sc, input int c, input logic e_rd, input int e_w, input int e_a,
                     input logic e_ov, input int e_oa, input logic e_busy, input logic e_done);
    @(negedge clk);
    chk($sformatf("%s c%0d rd_en", sc, c), 32'(rd_en), 32'(e_rd));
    chk($sformatf("%s c%0d w_addr", sc, c), 32'(w_addr), e_w);
    chk($sformatf("%s c%0d act_addr", sc, c), 32'(act_addr), e_a);
    chk($sformatf("%s c%0d out_valid", sc, c), 32'(out_valid), 32'(e_ov));
    chk($sformatf("%s c%0d out_addr", sc, c), 32'(out_addr), e_oa);
    chk($sformatf("%s c%0d busy", sc, c), 32'(busy), 32'(e_busy));
    chk($sformatf("%s c%0d done", sc, c), 32'(done), 32'(e_done));
    $display("%s cycle %0d: rd_en=%0b w=%0d act=%0d ov=%0b oa=%0d busy=%0b done=%0b cnt=%0d",
             sc, c, rd_en, w_addr, act_addr, out_valid, out_addr, busy, done, sample_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #12;
    chk("reset rd_en", 32'(rd_en), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset done", 32'(done), 0);
    chk("reset sample_cnt", 32'(sample_cnt), 0);
    chk("reset w_addr", 32'(w_addr), 0);
    begin_cycle(); reset = 1'b1;
    @(negedge clk);
    chk("post-release out_valid", 32'(out_valid), 0);

    // basic sample
    begin_cycle(); start = 1'b1; row("basic", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cycle(); start = 1'b0; row("basic", 1, 1, 0, 0, 0, 0, 1, 0);
    begin_cycle(); row("basic", 2, 1, 1, 1, 0, 0, 1, 0);
    begin_cycle(); row("basic", 3, 1, 2, 0, 1, 0, 1, 0);
    begin_cycle(); row("basic", 4, 1, 3, 1, 1, 1, 1, 0);
    begin_cycle(); row("basic", 5, 0, 0, 0, 1, 2, 1, 0);
    begin_cycle(); row("basic", 6, 0, 0, 0, 1, 3, 1, 0);
    begin_cycle(); row("basic", 7, 0, 0, 0, 0, 0, 1, 1);
    chk("basic sample_cnt", 32'(sample_cnt), 1);
    begin_cycle(); row("basic", 8, 0, 0, 0, 0, 0, 0, 0);

    // hold for one cycle inside RUN
    begin_cycle(); start = 1'b1; row("hold", 0, 0, 0, 0, 0, 0, 0, 0);
    begin_cycle(); start = 1'b0; row("hold", 1, 1, 0, 0, 0, 0, 1, 0);
    begin_cycle(); hold = 1'b1;  row("hold", 2, 0, 1, 1, 0, 0, 1, 0);
    begin_cycle(); hold = 1'b0;  row("hold", 3, 1, 1, 1, 1, 0, 1, 0);
    begin_cycle(); row("hold", 4, 1, 2, 0, 0, 0, 1, 0);
    begin_cycle(); row("hold", 5, 1, 3, 1, 1, 1, 1, 0);
    begin_cycle(); hold = 1'b1;  row("hold", 6, 0, 0, 0, 1, 2, 1, 0);
    begin_cycle(); row("hold", 7, 0, 0, 0, 1, 3, 1, 0);
    begin_cycle(); hold = 1'b0;  row("hold", 8, 0, 0, 0, 0, 0, 1, 1);
    chk("hold sample_cnt", 32'(sample_cnt), 2);
    begin_cycle(); row("hold", 9, 0, 0, 0, 0, 0, 0, 0);

    // start held high: back-to-back samples with one IDLE cycle between
    for (int c = 0; c <= 16; c++) begin
      begin_cycle();
      if (c == 0) start = 1'b1;
      if (c == 15) start = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b c%0d busy", c), 32'(busy), 32'(!(c == 0 || c == 8 || c == 16)));
      chk($sformatf("b2b c%0d done", c), 32'(done), 32'(c == 7 || c == 15));
      $display("b2b cycle %0d: busy=%0b done=%0b cnt=%0d", c, busy, done, sample_cnt);
    end
    chk("b2b sample_cnt", 32'(sample_cnt), 4);

    // start pulsed mid-RUN is ignored
    ov_seen = 0; done_seen = 0;
    for (int c = 0; c < 14; c++) begin
      begin_cycle();
      start = (c == 0 || c == 2);
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("midstart out_addr #%0d", ov_seen), 32'(out_addr), ov_seen);
        ov_seen++;
      end
      if (done) done_seen++;
      $display("midstart cycle %0d: ov=%0b oa=%0d done=%0b", c, out_valid, out_addr, done);
    end
    chk("midstart out_valid count", ov_seen, 4);
    chk("midstart done count", done_seen, 1);
    chk("midstart sample_cnt", 32'(sample_cnt), 5);
    chk("midstart idle busy", 32'(busy), 0);

    // reset asserted mid-RUN at cycle 3
    begin_cycle(); start = 1'b1;
    begin_cycle(); start = 1'b0;
    begin_cycle();
    begin_cycle(); reset = 1'b0; #1;
    chk("abort rd_en", 32'(rd_en), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort out_valid", 32'(out_valid), 0);
    chk("abort done", 32'(done), 0);
    chk("abort w_addr", 32'(w_addr), 0);
    chk("abort act_addr", 32'(act_addr), 0);
    chk("abort out_addr", 32'(out_addr), 0);
    chk("abort sample_cnt", 32'(sample_cnt), 0);
    $display("abort: reset asserted, busy=%0b ov=%0b cnt=%0d", busy, out_valid, sample_cnt);
    begin_cycle();
    begin_cycle(); reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("after-abort c%0d out_valid", c), 32'(out_valid), 0);
      chk($sformatf("after-abort c%0d done", c), 32'(done), 0);
      chk($sformatf("after-abort c%0d busy", c), 32'(busy), 0);
      $display("after-abort cycle %0d: ov=%0b done=%0b busy=%0b", c, out_valid, done, busy);
      begin_cycle();
    end
    ov_seen = 0; done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("rerun out_addr #%0d", ov_seen), 32'(out_addr), ov_seen);
        ov_seen++;
      end
      if (done) done_seen++;
      $display("rerun cycle %0d: ov=%0b oa=%0d done=%0b", c, out_valid, out_addr, done);
      begin_cycle();
    end
    start = 1'b0;
    chk("rerun out_valid count", ov_seen, 4);
    chk("rerun done count", done_seen, 1);
    chk("rerun sample_cnt", 32'(sample_cnt), 1);

    // LAT=3 build: output trails issue by 4 cycles, DRAIN lasts 4 cycles
    for (int c = 0; c <= 10; c++) begin
      start3 = (c == 0);
      @(negedge clk);
      chk($sformatf("lat3 c%0d rd_en", c), 32'(rd_en_3), 32'(c >= 1 && c <= 4));
      chk($sformatf("lat3 c%0d out_valid", c), 32'(out_valid_3), 32'(c >= 5 && c <= 8));
      chk($sformatf("lat3 c%0d out_addr", c), 32'(out_addr_3), (c >= 5 && c <= 8) ? c - 5 : 0);
      chk($sformatf("lat3 c%0d busy", c), 32'(busy_3), 32'(c >= 1 && c <= 9));
      chk($sformatf("lat3 c%0d done", c), 32'(done_3), 32'(c == 9));
      $display("lat3 cycle %0d: rd_en=%0b w=%0d ov=%0b oa=%0d busy=%0b done=%0b",
               c, rd_en_3, w_addr_3, out_valid_3, out_addr_3, busy_3, done_3);
      begin_cycle();
    end
    start3 = 1'b0;
    chk("lat3 sample_cnt", 32'(sample_cnt_3), 1);
    chk("lat3 act_addr idle", 32'(act_addr_3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
